// File: rtl/alu_pkg.sv
// Shared definitions for the HI/LO accumulator: op encodings, datapath widths
// and the accumulate state machine encoding.
package alu_pkg;

    localparam int HILO_W = 64;
    localparam int HALF_W = 32;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MUL   = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MADDU = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADD_LO = 2'd1,
        ST_ADD_HI = 2'd2
    } hilo_state_e;

    // Signed add overflows when both addends share a sign the result lacks.
    function automatic logic signed_add_ovf(input logic a_sign, input logic b_sign,
                                            input logic r_sign);
        return (a_sign == b_sign) && (r_sign != a_sign);
    endfunction

endpackage

// File: rtl/hilo_add32.sv
// 32-bit ripple adder slice with carry-in/carry-out, used for each accumulator half.
module hilo_add32
    import alu_pkg::*;
(
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    input  logic              cin,
    output logic [HALF_W-1:0] sum,
    output logic              cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{HALF_W{1'b0}}, cin};

endmodule

// File: rtl/hilo_unit.sv
// HI/LO accumulator behind the ALU multiplier: commits products, accumulates
// with an optional two-cycle split carry chain, and reports accumulate overflow.
module hilo_unit
    import alu_pkg::*;
#(
    parameter int ADD_SPLIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [HILO_W-1:0] mult_res,
    input  logic [HALF_W-1:0] wdata,
    output logic [HALF_W-1:0] hi,
    output logic [HALF_W-1:0] lo,
    output logic [HILO_W-1:0] mult_in,
    output logic              busy,
    output logic              done,
    output logic              acc_ovf
);

    hilo_state_e       state_r, state_nx_s;
    logic [HALF_W-1:0] hi_r, hi_nx_s, lo_r, lo_nx_s;
    logic [HILO_W-1:0] operand_r, operand_nx_s;
    logic              signed_r, signed_nx_s;
    logic [HALF_W:0]   sum_lo_r, sum_lo_nx_s;
    logic              busy_r, done_r, done_nx_s, ovf_r, ovf_nx_s;
    logic              accept_s;

    logic [HALF_W-1:0] add_lo_b_s, add_lo_sum_s, add_hi_b_s, add_hi_sum_s;
    logic              add_lo_cout_s, add_hi_cin_s, add_hi_cout_s;

    // Split mode feeds the adders from latched state; single-cycle mode chains them off the live product.
    always_comb begin
        if (ADD_SPLIT != 0) begin
            add_lo_b_s   = operand_r[HALF_W-1:0];
            add_hi_b_s   = operand_r[HILO_W-1:HALF_W];
            add_hi_cin_s = sum_lo_r[HALF_W];
        end else begin
            add_lo_b_s   = mult_res[HALF_W-1:0];
            add_hi_b_s   = mult_res[HILO_W-1:HALF_W];
            add_hi_cin_s = add_lo_cout_s;
        end
    end

    hilo_add32 u_add_lo (
        .a    (lo_r),
        .b    (add_lo_b_s),
        .cin  (1'b0),
        .sum  (add_lo_sum_s),
        .cout (add_lo_cout_s)
    );

    hilo_add32 u_add_hi (
        .a    (hi_r),
        .b    (add_hi_b_s),
        .cin  (add_hi_cin_s),
        .sum  (add_hi_sum_s),
        .cout (add_hi_cout_s)
    );

    assign accept_s = in_valid && (state_r == ST_IDLE);

    // Next-state and next-register values for the whole unit.
    always_comb begin
        state_nx_s   = state_r;
        hi_nx_s      = hi_r;
        lo_nx_s      = lo_r;
        operand_nx_s = operand_r;
        signed_nx_s  = signed_r;
        sum_lo_nx_s  = sum_lo_r;
        done_nx_s    = 1'b0;
        ovf_nx_s     = ovf_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (in_op)
                        OP_MUL: begin
                            hi_nx_s   = mult_res[HILO_W-1:HALF_W];
                            lo_nx_s   = mult_res[HALF_W-1:0];
                            done_nx_s = 1'b1;
                        end
                        OP_MTHI: begin
                            hi_nx_s   = wdata;
                            done_nx_s = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_nx_s   = wdata;
                            done_nx_s = 1'b1;
                        end
                        OP_MADD, OP_MADDU: begin
                            if (ADD_SPLIT != 0) begin
                                operand_nx_s = mult_res;
                                signed_nx_s  = (in_op == OP_MADD);
                                state_nx_s   = ST_ADD_LO;
                            end else begin
                                hi_nx_s   = add_hi_sum_s;
                                lo_nx_s   = add_lo_sum_s;
                                ovf_nx_s  = (in_op == OP_MADD) ?
                                    signed_add_ovf(hi_r[HALF_W-1], mult_res[HILO_W-1],
                                                   add_hi_sum_s[HALF_W-1]) :
                                    add_hi_cout_s;
                                done_nx_s = 1'b1;
                            end
                        end
                        default: begin
                            state_nx_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ADD_LO: begin
                sum_lo_nx_s = {add_lo_cout_s, add_lo_sum_s};
                state_nx_s  = ST_ADD_HI;
            end
            ST_ADD_HI: begin
                hi_nx_s    = add_hi_sum_s;
                lo_nx_s    = sum_lo_r[HALF_W-1:0];
                ovf_nx_s   = signed_r ?
                    signed_add_ovf(hi_r[HALF_W-1], operand_r[HILO_W-1], add_hi_sum_s[HALF_W-1]) :
                    add_hi_cout_s;
                done_nx_s  = 1'b1;
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            hi_r      <= {HALF_W{1'b0}};
            lo_r      <= {HALF_W{1'b0}};
            operand_r <= {HILO_W{1'b0}};
            signed_r  <= 1'b0;
            sum_lo_r  <= {(HALF_W+1){1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            hi_r      <= hi_nx_s;
            lo_r      <= lo_nx_s;
            operand_r <= operand_nx_s;
            signed_r  <= signed_nx_s;
            sum_lo_r  <= sum_lo_nx_s;
            busy_r    <= (state_nx_s != ST_IDLE);
            done_r    <= done_nx_s;
            ovf_r     <= ovf_nx_s;
        end
    end

    assign in_ready = (state_r == ST_IDLE);
    assign hi       = hi_r;
    assign lo       = lo_r;
    assign mult_in  = {hi_r, lo_r};
    assign busy     = busy_r;
    assign done     = done_r;
    assign acc_ovf  = ovf_r;

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Owns the 64-bit HI/LO accumulator that sits on the other end of the ALU multiply interface.
- Drives the ALU's current-HI/LO input (`mult_in`).
- Consumes the ALU's 64-bit product (`mult_res`) and commits it per op: mul overwrites, madd/maddu accumulate, mthi/mtlo write one half.
- Accumulation uses a split two-cycle 32-bit carry chain, with a valid/ready handshake that stalls issue while an accumulate is in flight.

Parameters:
- ADD_SPLIT, 1, 1 = two-cycle split add (low half, then high half plus carry); 0 = single-cycle 64-bit add.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  op request
- in_ready  out  1  unit can accept an op this cycle
- in_op  in  3  op: NOP=0, MUL=1, MADD=2, MADDU=3, MTHI=4, MTLO=5; 6-7 reserved
- mult_res  in  64  product from ALU, sampled on accept
- wdata  in  32  source for MTHI/MTLO, sampled on accept
- hi  out  32  committed HI
- lo  out  32  committed LO
- mult_in  out  64  {hi,lo}, fed to ALU
- busy  out  1  accumulate in flight
- done  out  1  one-cycle pulse, cycle after commit
- acc_ovf  out  1  overflow of last MADD (signed) / carry-out of last MADDU; held until next MADD/MADDU

Behaviour:
- Reset values:
  - hi = lo = 0; mult_in = 0
  - busy = 0, done = 0, acc_ovf = 0
  - in_ready = 1; state = IDLE
- Accept: an op is accepted when in_valid & in_ready at a rising edge. in_ready = (state == IDLE).
- States (ADD_SPLIT=1): IDLE, ADD_LO, ADD_HI.
- IDLE:
  - MUL accepted: {hi,lo} <= mult_res at that edge; done = 1 next cycle; stay IDLE.
  - MTHI accepted: hi <= wdata; same timing as MUL; lo unchanged.
  - MTLO accepted: lo <= wdata; same timing as MUL; hi unchanged.
  - NOP or reserved op accepted: no state change, no done.
  - MADD/MADDU accepted: latch operand = mult_res and op; -> ADD_LO.
- ADD_LO:
  - Registers sum_lo = lo + operand[31:0] (33 bits; bit 32 = carry).
  - busy = 1, in_ready = 0. hi/lo are not yet updated.
  - -> ADD_HI.
- ADD_HI:
  - sum_hi = hi + operand[63:32] + carry.
  - Commits {hi,lo} <= {sum_hi, sum_lo[31:0]} at the exiting edge.
  - acc_ovf:
    - MADD: signed 64-bit overflow (operand signs equal and result sign differs).
    - MADDU: carry-out of bit 63.
  - -> IDLE; done = 1 the following cycle.
- Latency (ADD_SPLIT=1, accept at edge T):
  - busy high during cycles T..T+1.
  - New hi/lo visible after edge T+2; done high in cycle T+2; in_ready high again in cycle T+2.
- Latency (ADD_SPLIT=0):
  - MADD/MADDU commit at the accept edge, like MUL; busy is never asserted; ADD_LO/ADD_HI unused.
- Arithmetic: all sums are modulo 2^64; wrap-around is silent except for acc_ovf.
- mult_in is always the committed {hi,lo}. It is never forwarded mid-accumulate; the issuer must wait for in_ready.
- in_valid while in_ready = 0 is ignored. The requester holds its op until accepted.
- Reset mid-operation: the in-flight accumulate is dropped, all state returns to reset values, and no done pulse is produced.
- done and acc_ovf are registered; no combinational path from in_* to any output except in_ready (from state only).

Decomposition:
- Shared package (alu_pkg): hilo op encodings (NOP..MTLO), HILO_W = 64, HALF_W = 32, hilo state enum.
- One natural sub-module: hilo_add32, a 32-bit adder with carry-in/carry-out. It is instantiated for the low and high halves (or chained combinationally when ADD_SPLIT = 0).

Test Plan:
- Reset then idle -> hi = lo = 0, mult_in = 0, in_ready = 1, busy = 0, done = 0.
- MUL mult_res = 64'h0000_0000_FFFF_FFFF, then MADDU mult_res = 64'h1 -> after the MUL, in_ready = 1 and done pulses. Accumulate result: hi = 32'h1, lo = 32'h0 (carry crosses halves), acc_ovf = 0, busy for 2 cycles, done in cycle T+2.
- MUL 64'h7FFF_FFFF_FFFF_FFFF, then MADD 64'h1 -> {hi,lo} = 64'h8000_0000_0000_0000, acc_ovf = 1.
- MUL 64'hFFFF_FFFF_FFFF_FFFF, then MADDU 64'h2 -> {hi,lo} = 64'h1, acc_ovf = 1. A following MADD 64'h1 -> {hi,lo} = 64'h2, acc_ovf = 0.
- MTHI wdata = 32'hDEAD_BEEF, MTLO wdata = 32'h1234_5678 -> mult_in = 64'hDEAD_BEEF_1234_5678. in_valid held with MUL during an in-flight MADD -> the MUL is not accepted until in_ready rises, then commits.
- Assert rst in the ADD_HI cycle of a MADD -> next cycle all outputs at reset values, no done pulse, in_ready = 1.
